// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin scheduler sharing one UART transmitter among N_REQ requesters,
// with start strobe, busy tracking, inter-frame gap and sticky start-timeout flag.
module tx_arbiter #(
   parameter int N_REQ      = 4,
   parameter int GAP_CYCLES = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [4*N_REQ-1:0]       req_dado,
   input  logic [4*N_REQ-1:0]       req_instrucao,
   output logic [N_REQ-1:0]         req_ready,
   input  logic                     tx_busy,
   output logic [3:0]               tx_dado,
   output logic [3:0]               tx_instrucao,
   output logic                     tx_botao,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     ativo,
   output logic                     erro
);
   localparam int GW   = $clog2(N_REQ);
   localparam int MAXC = TIMEOUT > GAP_CYCLES ? TIMEOUT : GAP_CYCLES;
   localparam int CW   = MAXC < 1 ? 1 : $clog2(MAXC + 1);

   typedef enum logic [2:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP} state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [GW-1:0]    grant_q, win_d;
   logic [3:0]       dado_q, instr_q, dado_d, instr_d;
   logic             botao_q, ativo_q, erro_q;
   logic [N_REQ-1:0] ready_q;

   // nearest valid index after the last grant wins; descending offsets let the nearest overwrite
   always_comb begin
      win_d = grant_q;
      dado_d = '0;
      instr_d = '0;
      for (int i = N_REQ; i >= 1; i--)
         for (int j = 0; j < N_REQ; j++)
            if (j == (int'(grant_q) + i) % N_REQ && req_valid[j]) begin
               win_d = GW'(j);
               dado_d = req_dado[4*j +: 4];
               instr_d = req_instrucao[4*j +: 4];
            end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q <= '0;
         grant_q <= GW'(N_REQ - 1);
         dado_q <= '0;
         instr_q <= '0;
         botao_q <= 1'b0;
         ready_q <= '0;
         ativo_q <= 1'b0;
         erro_q <= 1'b0;
      end else begin
         botao_q <= 1'b0;
         ready_q <= '0;
         cnt_q <= '0;
         case (state_q)
            IDLE: if (|req_valid) begin
               state_q <= LOAD;
               ativo_q <= 1'b1;
               grant_q <= win_d;
               dado_q <= dado_d;
               instr_q <= instr_d;
               botao_q <= 1'b1;
               ready_q <= N_REQ'(1) << win_d;
            end
            LOAD: state_q <= WAIT_BUSY;
            WAIT_BUSY: if (tx_busy) state_q <= WAIT_DONE;
               else if (int'(cnt_q) == TIMEOUT - 1) begin
                  erro_q <= 1'b1;
                  state_q <= GAP_CYCLES == 0 ? IDLE : GAP;
                  ativo_q <= GAP_CYCLES != 0;
               end else cnt_q <= cnt_q + 1'b1;
            WAIT_DONE: if (!tx_busy) begin
               state_q <= GAP_CYCLES == 0 ? IDLE : GAP;
               ativo_q <= GAP_CYCLES != 0;
            end
            GAP: if (int'(cnt_q) == GAP_CYCLES - 1) begin
               state_q <= IDLE;
               ativo_q <= 1'b0;
            end else cnt_q <= cnt_q + 1'b1;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready    = ready_q;
   assign tx_dado      = dado_q;
   assign tx_instrucao = instr_q;
   assign tx_botao     = botao_q;
   assign grant_id     = grant_q;
   assign ativo        = ativo_q;
   assign erro         = erro_q;
endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed and randomized frames on a default instance and a
// 3-requester, zero-gap, short-timeout instance, checked against a transaction-level model.
module tb_tx_arbiter;
   logic        clk = 1'b0, rst = 1'b1;
   logic [3:0]  v0 = '0, r0, td0, ti0;
   logic [15:0] d0 = '0, i0 = '0;
   logic        b0 = 1'b0, bt0, a0, e0;
   logic [1:0]  g0;
   logic [2:0]  v1 = '0, r1;
   logic [11:0] d1 = '0, i1 = '0;
   logic        b1 = 1'b0, bt1, a1, e1;
   logic [1:0]  g1;
   logic [3:0]  td1, ti1;
   int errors = 0, checks = 0, last0 = 3, last1 = 2;

   always #5 clk = ~clk;

   tx_arbiter u0 (
      .clk(clk), .rst(rst), .req_valid(v0), .req_dado(d0), .req_instrucao(i0),
      .req_ready(r0), .tx_busy(b0), .tx_dado(td0), .tx_instrucao(ti0),
      .tx_botao(bt0), .grant_id(g0), .ativo(a0), .erro(e0)
   );

   tx_arbiter #(.N_REQ(3), .GAP_CYCLES(0), .TIMEOUT(6)) u1 (
      .clk(clk), .rst(rst), .req_valid(v1), .req_dado(d1), .req_instrucao(i1),
      .req_ready(r1), .tx_busy(b1), .tx_dado(td1), .tx_instrucao(ti1),
      .tx_botao(bt1), .grant_id(g1), .ativo(a1), .erro(e1)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
      end
   endtask

   // first valid index after `last`, wrapping modulo n
   function automatic int rr(input int last, input logic [7:0] mask, input int n);
      for (int k = 1; k <= n; k++)
         if (mask[(last + k) % n]) return (last + k) % n;
      return -1;
   endfunction

   // one complete frame on u0: TX raises busy dly cycles after the strobe and holds it len cycles
   task automatic frame0(input logic [3:0] mask, input logic [15:0] dv, input logic [15:0] iv,
                         input int dly, input int len, input string tag);
      int w, n;
      logic [3:0] dd, ii;
      w = rr(last0, 8'(mask), 4);
      v0 = mask;
      d0 = dv;
      i0 = iv;
      dd = dv[4*w +: 4];
      ii = iv[4*w +: 4];
      tick;
      chk({tag, " strobe"}, 32'({bt0, r0, a0}), 32'({1'b1, 4'(1 << w), 1'b1}));
      chk({tag, " grant"}, 32'(g0), 32'(w));
      chk({tag, " data"}, 32'({td0, ti0}), 32'({dd, ii}));
      last0 = w;
      b0 = (dly == 0);
      for (int k = 1; k <= dly + len; k++) begin
         v0 = 4'($urandom);
         d0 = 16'($urandom);
         i0 = 16'($urandom);
         tick;
         chk({tag, " hold"}, 32'({bt0, r0, td0, ti0, a0}), 32'({1'b0, 4'b0, dd, ii, 1'b1}));
         if (k == dly) b0 = 1'b1;
      end
      b0 = 1'b0;
      n = 0;
      do begin
         v0 = 4'($urandom);
         tick;
         n++;
      end while (a0 === 1'b1 && n < 40);
      chk({tag, " gap"}, 32'(n), 32'(17));
      chk({tag, " kept"}, 32'({bt0, td0, ti0}), 32'({1'b0, dd, ii}));
   endtask

   initial begin
      int w, n;
      logic [3:0] m;
      #2 rst = 1'b0;
      tick;
      tick;
      chk("reset u0", 32'({bt0, r0, td0, ti0, g0, a0, e0}), 32'({1'b0, 4'b0, 4'b0, 4'b0, 2'd3, 1'b0, 1'b0}));
      chk("reset u1", 32'({bt1, r1, td1, ti1, g1, a1, e1}), 32'({1'b0, 3'b0, 4'b0, 4'b0, 2'd2, 1'b0, 1'b0}));
      rst = 1'b1;
      tick;
      frame0(4'b0001, 16'h000A, 16'h0003, 2, 40, "single");
      for (int k = 0; k < 8; k++) begin
         frame0(4'b1111, 16'($urandom), 16'($urandom), 1, 5, "rr");
         chk("rr order", 32'(g0), 32'((k + 1) % 4));
      end
      frame0(4'b0100, 16'($urandom), 16'($urandom), 1, 3, "skip to 2");
      frame0(4'b0011, 16'($urandom), 16'($urandom), 1, 3, "wrap to 0");
      frame0(4'b0011, 16'($urandom), 16'($urandom), 1, 3, "then 1");
      for (int t = 0; t < 30; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            v0 = '0;
            tick;
            chk("idle", 32'({bt0, a0, r0}), 32'(0));
         end
         frame0(4'($urandom_range(1, 15)), 16'($urandom), 16'($urandom),
                int'($urandom_range(0, 4)), int'($urandom_range(2, 12)), "rand");
      end
      // start timeout: busy never rises
      m = 4'($urandom_range(1, 15));
      w = rr(last0, 8'(m), 4);
      v0 = m;
      tick;
      chk("to strobe", 32'({bt0, g0}), 32'({1'b1, 2'(w)}));
      last0 = w;
      v0 = '0;
      tick;
      repeat (254) tick;
      chk("to erro early", 32'(e0), 32'(0));
      tick;
      chk("to erro", 32'({e0, a0}), 32'({1'b1, 1'b1}));
      n = 0;
      do begin
         tick;
         n++;
      end while (a0 === 1'b1 && n < 40);
      chk("to gap", 32'(n), 32'(16));
      frame0(4'($urandom_range(1, 15)), 16'($urandom), 16'($urandom), 2, 4, "after to");
      chk("erro sticky", 32'(e0), 32'(1));
      // zero gap, short timeout: busy arriving on the last allowed cycle
      w = rr(last1, 8'(3'b111), 3);
      v1 = 3'b111;
      d1 = 12'($urandom);
      i1 = 12'($urandom);
      tick;
      chk("b strobe", 32'({bt1, r1, g1}), 32'({1'b1, 3'(1 << w), 2'(w)}));
      chk("b data", 32'({td1, ti1}), 32'({d1[4*w +: 4], i1[4*w +: 4]}));
      last1 = w;
      v1 = '0;
      tick;
      repeat (5) tick;
      b1 = 1'b1;
      tick;
      chk("b busy wins", 32'({e1, a1}), 32'({1'b0, 1'b1}));
      repeat (2) tick;
      b1 = 1'b0;
      tick;
      chk("b idle next", 32'(a1), 32'(0));
      w = rr(last1, 8'(3'b110), 3);
      v1 = 3'b110;
      tick;
      chk("late strobe", 32'({bt1, g1}), 32'({1'b1, 2'(w)}));
      last1 = w;
      v1 = '0;
      tick;
      repeat (5) tick;
      chk("late erro early", 32'(e1), 32'(0));
      tick;
      chk("late erro", 32'(e1), 32'(1));
      w = rr(last1, 8'(3'b101), 3);
      v1 = 3'b101;
      n = 0;
      do begin
         tick;
         n++;
      end while (bt1 !== 1'b1 && n < 8);
      chk("after late", 32'({bt1, g1, e1}), 32'({1'b1, 2'(w), 1'b1}));
      last1 = w;
      v1 = '0;
      b1 = 1'b1;
      repeat (2) tick;
      b1 = 1'b0;
      tick;
      chk("after late idle", 32'(a1), 32'(0));
      w = rr(last1, 8'(3'b111), 3);
      v1 = 3'b111;
      tick;
      chk("n3 wrap", 32'({bt1, g1}), 32'({1'b1, 2'(w)}));
      last1 = w;
      v1 = '0;
      b1 = 1'b1;
      repeat (2) tick;
      b1 = 1'b0;
      tick;
      chk("n3 wrap idle", 32'(a1), 32'(0));
      // reset in WAIT_DONE, away from any clock edge
      w = rr(last0, 8'(4'b1111), 4);
      v0 = 4'b1111;
      tick;
      chk("mid strobe", 32'(g0), 32'(w));
      v0 = '0;
      b0 = 1'b1;
      repeat (3) tick;
      chk("mid active", 32'(a0), 32'(1));
      #3 rst = 1'b0;
      #1;
      chk("async reset u0", 32'({bt0, r0, td0, ti0, g0, a0, e0}), 32'({1'b0, 4'b0, 4'b0, 4'b0, 2'd3, 1'b0, 1'b0}));
      chk("async reset u1", 32'({e1, g1, a1}), 32'({1'b0, 2'd2, 1'b0}));
      last0 = 3;
      last1 = 2;
      b0 = 1'b0;
      repeat (2) tick;
      rst = 1'b1;
      frame0(4'b1111, 16'($urandom), 16'($urandom), 1, 4, "post reset");
      chk("post reset first", 32'(g0), 32'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
